risc_mem_responder: RTL and testbench
=====================================

Name: risc_mem_responder

Overview:
- Memory-side responder for the proRISC CPU's data/instruction bus. The CPU is the initiator; this block is the target.
- Serves single-word reads and writes from an internal RAM with a programmable number of wait states.
- Maps one address to an output port register, so a bench can observe program results.
- Has a preload port, so benches can write a program image while the CPU is held in reset.

Parameters:
- ADDR_WIDTH, 5, bus address width; RAM depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width.
- WAIT_STATES, 1, extra cycles inserted before ready; legal range 0..15.
- IO_ADDR, 31, address decoded as the output port register instead of RAM.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd  in  1  CPU read request; held until ready is seen.
- wr  in  1  CPU write request; held until ready is seen.
- addr  in  ADDR_WIDTH  request address; stable while rd or wr is high.
- wdata  in  DATA_WIDTH  write data; stable while wr is high.
- rdata  out  DATA_WIDTH  read data; valid only in the cycle ready is high.
- ready  out  1  one-cycle completion strobe.
- err  out  1  sticky flag, set when rd and wr are sampled high together.
- io_data  out  DATA_WIDTH  output port register.
- io_valid  out  1  one-cycle pulse when io_data is written.
- ld_en  in  1  preload write enable; honoured only while reset is high.
- ld_addr  in  ADDR_WIDTH  preload address.
- ld_data  in  DATA_WIDTH  preload data.

Behaviour:
- Reset (synchronous, while reset=1):
  - state=IDLE, ready=0, rdata=0, err=0, io_data=0, io_valid=0, wait counter=0.
  - RAM contents are not cleared.
  - If ld_en=1: RAM[ld_addr] <= ld_data, including ld_addr==IO_ADDR (RAM word written; io_data unaffected).
  - ld_en is ignored when reset=0.
  - Reset asserted mid-transaction aborts it: no RAM write, no ready, state=IDLE next cycle.
- FSM states: IDLE, WAIT, RESP, DONE.
- IDLE:
  - Samples rd|wr. If high: latch addr, wdata and the op type; load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else RESP.
  - rd=wr=1: treated as a write, err set to 1 (sticky until reset).
- WAIT: counter decrements each cycle; go to RESP when counter reaches 1.
- RESP (exactly one cycle, ready=1):
  - Read, RAM address: rdata = RAM[latched addr].
  - Read, IO_ADDR: rdata = io_data.
  - Write, RAM address: RAM updated at the end of this cycle.
  - Write, IO_ADDR: io_data <= wdata, io_valid=1 for the following cycle; RAM not written.
  - Outside RESP, rdata holds 0.
  - Go to DONE.
- DONE: four-phase return-to-zero. Stay until rd=wr=0 is sampled, then go to IDLE. A request held high across ready is never serviced twice.
- Latency:
  - Request first sampled at edge k; ready is high in the cycle after edge k+1+WAIT_STATES (WAIT_STATES=0: one cycle after sampling).
  - Minimum request-to-request spacing is WAIT_STATES+3 cycles.
- Address and data changes by the requester during WAIT/RESP are ignored; the latched values are used.
- Address wrap: addr is exactly ADDR_WIDTH bits; no out-of-range case exists.
- A read issued right after a write to the same address returns the new data.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Preload: reset=1, ld_en writes RAM[3]=8'hA5; release reset; read addr 3 with WAIT_STATES=1 -> ready exactly 3 cycles after rd rises (sampled at edge k, high in the cycle after edge k+2), rdata=8'hA5, err=0.
- Write/read-back: write 8'h3C to addr 7, deassert, then read addr 7 -> rdata=8'h3C; one ready pulse per transaction.
- IO port: write 8'h5A to addr 31 -> io_valid high for exactly one cycle, io_data=8'h5A; read addr 31 -> 8'h5A; preloaded RAM[31] unchanged.
- Held request: keep rd high for 10 cycles after ready -> no second ready; drop rd, re-raise -> new transaction completes normally.
- Collision: rd=wr=1, addr 2, wdata 8'h11 -> err=1 and stays 1; subsequent read of addr 2 returns 8'h11.
- Reset mid-op: raise wr to addr 4 (RAM[4]=8'h00), assert reset during WAIT -> no ready, RAM[4] still 8'h00, io_data=0, err=0; WAIT_STATES=0 rerun -> ready one cycle after sampling.

Source files
------------

// File: rtl/risc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : risc_mem_responder
//  Purpose  : Memory-side target for the proRISC CPU bus. It serves single-word
//             reads and writes from an internal RAM after a programmable number
//             of wait states. One address is decoded as an output port
//             register, and a preload port fills the RAM while the system is in
//             reset.
//  Ports    : clk, reset          - clock and synchronous active-high reset
//             rd, wr, addr, wdata - CPU request (four-phase handshake)
//             rdata, ready        - response data and one-cycle done strobe
//             err                 - sticky flag for rd and wr high together
//             io_data, io_valid   - output port register and its write pulse
//             ld_en, ld_addr,
//             ld_data             - RAM preload, honoured only during reset
//  Revision : 1.0 - initial release
// ============================================================================
module risc_mem_responder #(
   parameter int ADDR_WIDTH  = 5,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_STATES = 1,
   parameter int IO_ADDR     = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] io_data,
   output logic                  io_valid,
   input  logic                  ld_en,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data
);

   localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] IO_SEL  = ADDR_WIDTH'(IO_ADDR);
   localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  state_q,    state_d;
   logic [3:0]              cnt_q,      cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
   logic                    is_wr_q,    is_wr_d;
   logic [DATA_WIDTH-1:0]   rdata_q,    rdata_d;
   logic                    ready_q,    ready_d;
   logic                    err_q,      err_d;
   logic [DATA_WIDTH-1:0]   io_data_q,  io_data_d;
   logic                    io_valid_q, io_valid_d;

   logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

   logic                    w_is_io;
   logic                    w_mem_we;

   assign w_is_io  = (addr_q == IO_SEL);
   assign w_mem_we = (state_q == S_RESP) && is_wr_q && !w_is_io;

   // Response outputs are computed during RESP and registered on the edge
   // that leaves it, so every output comes straight from a flop and ready is
   // visible in the first DONE cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      is_wr_d    = is_wr_q;
      rdata_d    = '0;
      ready_d    = 1'b0;
      err_d      = err_q;
      io_data_d  = io_data_q;
      io_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rd || wr) begin
               addr_d  = addr;
               wdata_d = wdata;
               // A collision is serviced as a write.
               is_wr_d = wr;
               cnt_d   = WAIT_INIT;
               if (rd && wr) begin
                  err_d = 1'b1;
               end
               state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
         end

         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            ready_d = 1'b1;
            if (is_wr_q) begin
               if (w_is_io) begin
                  io_data_d  = wdata_q;
                  io_valid_d = 1'b1;
               end
            end else begin
               rdata_d = w_is_io ? io_data_q : mem_q[addr_q];
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            // Wait for the requester to drop its strobe so a held request is
            // not serviced a second time.
            if (!rd && !wr) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         is_wr_q    <= 1'b0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         io_data_q  <= '0;
         io_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         is_wr_q    <= is_wr_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         io_data_q  <= io_data_d;
         io_valid_q <= io_valid_d;
      end
   end

   // RAM is never cleared; during reset only the preload port may write it,
   // which also aborts any bus write that was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
         end
      end else if (w_mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign rdata    = rdata_q;
   assign ready    = ready_q;
   assign err      = err_q;
   assign io_data  = io_data_q;
   assign io_valid = io_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_mem_responder
//  Purpose  : Self-checking bench for risc_mem_responder. One instance runs
//             with one wait state, a second with zero wait states. Expected
//             values come from a simple memory/port model kept in the bench.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_risc_mem_responder;

   localparam int WS1 = 1;

   logic       clk = 1'b0;
   logic       reset, rst0;
   logic       rd, wr;
   logic [4:0] addr;
   logic [7:0] wdata;
   logic       ld_en;
   logic [4:0] ld_addr;
   logic [7:0] ld_data;

   logic [7:0] rdata1, io_data1, rdata0, io_data0;
   logic       ready1, err1, io_valid1, ready0, err0, io_valid0;

   int total = 0;
   int bad   = 0;

   // Reference model: RAM image, port register and sticky error flag.
   logic [7:0] mem_m [32];
   logic [7:0] io_m;
   logic       err_m;

   always #5 clk = ~clk;

   risc_mem_responder #(
      .ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_STATES(WS1), .IO_ADDR(31)
   ) u1 (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .ready(ready1), .err(err1), .io_data(io_data1),
      .io_valid(io_valid1), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   risc_mem_responder #(
      .ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_STATES(0), .IO_ADDR(31)
   ) u0 (
      .clk(clk), .reset(rst0), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata0), .ready(ready0), .err(err0), .io_data(io_data0),
      .io_valid(io_valid0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one request, wait (bounded) for ready on each active instance,
   // then drop the request and sample one cycle later.
   task automatic raw(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d,
                      output int lat1, output int lat0, output logic [7:0] rd1,
                      output logic iov1, output logic [7:0] rd0,
                      output logic rdy_after, output logic iov_after);
      bit done1, done0;
      int n;
      @(negedge clk);
      rd = r; wr = w; addr = a; wdata = d;
      lat1 = 0; lat0 = 0; rd1 = '0; iov1 = 1'b0; rd0 = '0;
      done1 = 1'b0; done0 = rst0; n = 0;
      while (!(done1 && done0) && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (!done1 && ready1) begin
            done1 = 1'b1; lat1 = n; rd1 = rdata1; iov1 = io_valid1;
         end
         if (!done0 && ready0) begin
            done0 = 1'b1; lat0 = n; rd0 = rdata0;
         end
      end
      rd = 1'b0; wr = 1'b0;
      @(posedge clk); #1;
      rdy_after = ready1;
      iov_after = io_valid1;
   endtask

   // One transaction on the one-wait-state instance, checked against the model.
   task automatic bus(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d,
                      input string tag);
      int         lat1, lat0;
      logic [7:0] rd1, rd0, exp_rd;
      logic       iov1, rdy_after, iov_after;
      raw(r, w, a, d, lat1, lat0, rd1, iov1, rd0, rdy_after, iov_after);
      chk({tag, ".latency"}, lat1, WS1 + 2);
      chk({tag, ".single_ready"}, rdy_after, 1'b0);
      if (w) begin
         if (a == 5'd31) io_m = d;
         else            mem_m[a] = d;
         if (r) err_m = 1'b1;
         chk({tag, ".io_valid"}, iov1, (a == 5'd31));
      end else begin
         exp_rd = (a == 5'd31) ? io_m : mem_m[a];
         chk({tag, ".rdata"}, rd1, exp_rd);
         chk({tag, ".io_valid"}, iov1, 1'b0);
      end
      chk({tag, ".io_valid_off"}, iov_after, 1'b0);
      chk({tag, ".io_data"}, io_data1, io_m);
      chk({tag, ".err"}, err1, err_m);
   endtask

   initial begin
      int         lat1, lat0, cnt;
      logic [7:0] rd1, rd0;
      logic       iov1, rdy_after, iov_after;
      logic       r;
      logic [4:0] a;

      reset = 1'b1; rst0 = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      io_m = '0; err_m = 1'b0;
      repeat (2) @(posedge clk);

      // Preload the whole RAM with a known image.
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         ld_en   = 1'b1;
         ld_addr = 5'(i);
         ld_data = (i == 3) ? 8'hA5 : (i == 4) ? 8'h00 : (i == 31) ? 8'h77 : 8'($urandom);
         mem_m[i] = ld_data;
      end
      @(negedge clk);
      ld_en = 1'b0;
      @(posedge clk); #1;
      chk("reset.ready",    ready1,    1'b0);
      chk("reset.rdata",    rdata1,    8'h00);
      chk("reset.err",      err1,      1'b0);
      chk("reset.io_data",  io_data1,  8'h00);
      chk("reset.io_valid", io_valid1, 1'b0);

      @(negedge clk);
      reset = 1'b0;
      // Preload must be ignored outside reset.
      ld_en = 1'b1; ld_addr = 5'd20; ld_data = ~mem_m[20];
      @(negedge clk);
      ld_en = 1'b0;

      bus(1'b1, 1'b0, 5'd3,  8'h00, "preload_read");
      bus(1'b1, 1'b0, 5'd20, 8'h00, "ld_ignored");
      bus(1'b0, 1'b1, 5'd7,  8'h3C, "write7");
      bus(1'b1, 1'b0, 5'd7,  8'h00, "readback7");
      bus(1'b0, 1'b1, 5'd31, 8'h5A, "io_write");
      bus(1'b1, 1'b0, 5'd31, 8'h00, "io_read");
      chk("io.ram31_kept", u1.mem_q[31], mem_m[31]);

      // Held request: rd stays high for ten cycles after ready.
      @(negedge clk);
      rd = 1'b1; addr = 5'd7;
      lat1 = 0; rd1 = '0;
      for (int n = 1; n <= 20 && lat1 == 0; n++) begin
         @(posedge clk); #1;
         if (ready1) begin lat1 = n; rd1 = rdata1; end
      end
      chk("held.latency", lat1, WS1 + 2);
      chk("held.rdata", rd1, mem_m[7]);
      cnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ready1) cnt++;
      end
      chk("held.no_repeat", cnt, 0);
      rd = 1'b0;
      @(posedge clk); #1;
      bus(1'b1, 1'b0, 5'd5, 8'h00, "after_held");

      // Randomised traffic, biased toward the port address.
      for (int i = 0; i < 16; i++) begin
         r = 1'($urandom);
         a = ($urandom % 4 == 0) ? 5'd31 : 5'($urandom);
         bus(r, !r, a, 8'($urandom), "random");
         if (!r) bus(1'b1, 1'b0, a, 8'h00, "random_raw");
      end

      // Collision: treated as a write, err becomes sticky.
      bus(1'b1, 1'b1, 5'd2, 8'h11, "collision");
      bus(1'b1, 1'b0, 5'd2, 8'h00, "collision_read");

      // Reset during WAIT aborts the write.
      @(negedge clk);
      wr = 1'b1; addr = 5'd4; wdata = 8'hEE;
      @(posedge clk); #1;
      chk("abort.no_ready0", ready1, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort.no_ready1", ready1, 1'b0);
      @(posedge clk); #1;
      chk("abort.no_ready2", ready1, 1'b0);
      @(negedge clk);
      wr = 1'b0; reset = 1'b0;
      io_m = 8'h00; err_m = 1'b0;
      @(posedge clk); #1;
      chk("abort.io_data", io_data1, 8'h00);
      chk("abort.err", err1, 1'b0);
      chk("abort.ready", ready1, 1'b0);
      bus(1'b1, 1'b0, 5'd4, 8'h00, "abort_read4");
      chk("final.ram31_kept", u1.mem_q[31], mem_m[31]);

      // Zero-wait-state instance: ready the cycle after sampling plus one.
      @(negedge clk);
      rst0 = 1'b0;
      raw(1'b1, 1'b0, 5'd3, 8'h00, lat1, lat0, rd1, iov1, rd0, rdy_after, iov_after);
      chk("ws0.read_latency", lat0, 2);
      chk("ws0.read_rdata", rd0, 8'hA5);
      raw(1'b0, 1'b1, 5'd9, 8'h6B, lat1, lat0, rd1, iov1, rd0, rdy_after, iov_after);
      mem_m[9] = 8'h6B;
      chk("ws0.write_latency", lat0, 2);
      raw(1'b1, 1'b0, 5'd9, 8'h00, lat1, lat0, rd1, iov1, rd0, rdy_after, iov_after);
      chk("ws0.readback_latency", lat0, 2);
      chk("ws0.readback_rdata", rd0, 8'h6B);
      chk("ws0.ws1_readback", rd1, mem_m[9]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
